bomb_game_ctrl: RTL and testbench
=================================

Name: bomb_game_ctrl

Overview:
Top-level game controller for the bomb, with a parametrised module count.
- Arms a random subset of puzzle modules using a free-running LFSR.
- Runs the countdown timer, counts strikes and latches per-module defuse status.
- Declares the game won (all armed modules defused) or lost (strike limit reached or timer expired).
- Sits between the game FSM and the puzzle modules. Display blocks consume seconds_left, strikes and state.

Parameters:
NUM_MODULES, 4, number of puzzle modules (1..16)
MAX_STRIKES, 3, strike count that loses the game (1..15)
TIME_SECONDS, 300, countdown start value (1..65535)
CLK_HZ, 27000000, clock cycles per timer second (>=2)
LFSR_SEED, 16'hACE1, nonzero LFSR reset value
RANDOM_EN, 1, 1 = random arming; 0 = arm all modules
MIN_ACTIVE, 1, fewer random enables than this forces all-ones

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
begin_setup  in  1  start-round pulse from the game FSM
module_defused  in  NUM_MODULES  per-module defused level/pulse
module_strike  in  NUM_MODULES  per-module single-cycle strike pulse
enable  out  NUM_MODULES  armed-module mask
accum_enable  out  1  high while ARMED
game_won  out  1  high in WON
game_lost  out  1  high in LOST
strikes  out  SW=$clog2(MAX_STRIKES+1)  strike count
seconds_left  out  16  remaining seconds
one_hz  out  1  one-cycle pulse per timer second
state  out  3  IDLE=0 SETUP=1 ARMED=2 WON=3 LOST=4

Behaviour:
- All outputs are registered. Every transition takes effect on the edge after the causing input is sampled.
- Reset state: IDLE; enable=0, accum_enable=0, game_won=0, game_lost=0, strikes=0, seconds_left=0, one_hz=0.
- Reset also clears the defuse latch and the prescaler, and sets the LFSR to LFSR_SEED.
- Reset mid-round has the same effect and returns to IDLE on the next edge.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Advances every cycle out of reset, in all states.
- IDLE: on begin_setup=1, go to SETUP.
- SETUP (exactly 1 cycle):
  - enable <= RANDOM_EN ? lfsr[NUM_MODULES-1:0] : all-ones.
  - If popcount of the random mask < MIN_ACTIVE, enable <= all-ones.
  - seconds_left <= TIME_SECONDS; strikes <= 0; defuse latch <= 0; prescaler <= 0.
  - Next state is ARMED.
- ARMED:
  - accum_enable=1.
  - Prescaler counts 0..CLK_HZ-1 and wraps. At the terminal count: one_hz=1 for that cycle, and seconds_left decrements by 1.
  - Defuse latch <= latch | (module_defused & enable). Inputs on disabled modules are ignored.
  - Valid strikes = module_strike & enable & ~latch. Their popcount is added to strikes in the same cycle; multiple simultaneous strikes all count.
  - strikes saturates at MAX_STRIKES.
- Exit conditions, evaluated each ARMED cycle on next-values:
  - lose_cond = next strikes >= MAX_STRIKES, OR (tick AND seconds_left==1).
  - win_cond = (next latch & enable) == enable.
  - lose_cond takes priority over win_cond when both occur in the same cycle.
- begin_setup is ignored in SETUP and ARMED.
- WON / LOST:
  - Terminal: accum_enable=0, one_hz=0.
  - enable, strikes and seconds_left are frozen.
  - game_won or game_lost is held at 1.
  - begin_setup=1 clears both flags and goes to SETUP, starting a new round.
- seconds_left never wraps below 0. strikes never exceeds MAX_STRIKES.

Test Plan:
- RANDOM_EN=0, NUM_MODULES=4: reset, then begin_setup pulse. Required: state goes 1 then 2 on successive edges, enable=4'hF, accum_enable=1, seconds_left=300.
- Armed, all 4 enabled: defused pulses on bits 0, 1, 1, 3, 2, in separate cycles. Required: game_won=1 and state=3 one cycle after the bit-2 pulse; accum_enable=0; the repeated bit 1 has no effect.
- MAX_STRIKES=3: strike pulse 4'b0101, then 4'b0010. Required: strikes=2 after the first, then 3 with game_lost=1 and state=4. A strike on an already-defused module does not change strikes.
- CLK_HZ=10, TIME_SECONDS=3: arm, apply no input. Required: one_hz every 10 cycles; seconds_left 3→2→1; state=LOST with seconds_left frozen at 1 on the 30th ARMED cycle.
- Final defuse and the third strike in the same cycle. Required: game_lost=1, game_won=0.
- begin_setup during ARMED is ignored. Reset mid-ARMED gives IDLE with all outputs 0 on the next edge. begin_setup from LOST starts a new round with strikes=0.

Source files
------------

// File: rtl/bomb_game_ctrl_if.sv
// Game controller bus: round control and puzzle-module signals in,
// arming mask, game status, strike count and timer out.
interface bomb_game_ctrl_if #(
  parameter int NUM_MODULES = 4,
  parameter int SW          = 2
);
  logic                   begin_setup;
  logic [NUM_MODULES-1:0] module_defused;
  logic [NUM_MODULES-1:0] module_strike;
  logic [NUM_MODULES-1:0] enable;
  logic                   accum_enable;
  logic                   game_won;
  logic                   game_lost;
  logic [SW-1:0]          strikes;
  logic [15:0]            seconds_left;
  logic                   one_hz;
  logic [2:0]             state;

  // Game FSM / puzzle side: drives round start and module events
  modport master (
    output begin_setup, module_defused, module_strike,
    input  enable, accum_enable, game_won, game_lost,
           strikes, seconds_left, one_hz, state
  );

  // Controller side
  modport slave (
    input  begin_setup, module_defused, module_strike,
    output enable, accum_enable, game_won, game_lost,
           strikes, seconds_left, one_hz, state
  );
endinterface

// File: rtl/bomb_game_ctrl.sv
// Bomb game controller: arms a (pseudo)random subset of puzzle modules,
// runs the countdown, counts strikes, latches defuse status and decides
// the outcome of a round. All outputs come straight from registers.
module bomb_game_ctrl #(
  parameter int          NUM_MODULES  = 4,
  parameter int          MAX_STRIKES  = 3,
  parameter int          TIME_SECONDS = 300,
  parameter int          CLK_HZ       = 27000000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int          RANDOM_EN    = 1,
  parameter int          MIN_ACTIVE   = 1
) (
  input logic              clock,
  input logic              reset,
  bomb_game_ctrl_if.slave  bus
);

  localparam int SW = $clog2(MAX_STRIKES + 1);
  localparam int PW = $clog2(CLK_HZ);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_ARMED = 3'd2;
  localparam logic [2:0] S_WON   = 3'd3;
  localparam logic [2:0] S_LOST  = 3'd4;

  // Galois taps for x^16+x^14+x^13+x^11+1 (right-shifting form)
  localparam logic [15:0]            LFSR_TAPS  = 16'hB400;
  localparam logic [NUM_MODULES-1:0] ALL_ONES   = {NUM_MODULES{1'b1}};
  localparam logic [PW-1:0]          PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [15:0]            TIME_INIT  = 16'(TIME_SECONDS);
  localparam logic [SW-1:0]          STRIKE_MAX = SW'(MAX_STRIKES);
  localparam logic [5:0]             STRIKE_LIM = 6'(MAX_STRIKES);
  localparam logic [5:0]             MIN_ACT    = 6'(MIN_ACTIVE);

  // Number of set bits in a module mask (at most 16, fits in 5 bits)
  function automatic logic [4:0] popcount(input logic [NUM_MODULES-1:0] v);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < NUM_MODULES; i++) begin
      cnt = cnt + 5'(v[i]);
    end
    return cnt;
  endfunction

  logic [2:0]             state_r;
  logic [15:0]            lfsr_r;
  logic [NUM_MODULES-1:0] enable_r;
  logic [NUM_MODULES-1:0] latch_r;
  logic [SW-1:0]          strikes_r;
  logic [15:0]            seconds_r;
  logic [PW-1:0]          presc_r;
  logic                   accum_r;
  logic                   won_r;
  logic                   lost_r;
  logic                   one_hz_r;

  logic [15:0]            lfsr_next_s;
  logic [NUM_MODULES-1:0] arm_mask_s;
  logic                   tick_s;
  logic                   timeout_s;
  logic [NUM_MODULES-1:0] latch_next_s;
  logic [NUM_MODULES-1:0] valid_strike_s;
  logic [5:0]             strike_sum_s;
  logic [SW-1:0]          strikes_next_s;
  logic                   lose_s;
  logic                   win_s;

  // LFSR step and the arming mask taken from the current LFSR value
  always_comb begin
    lfsr_next_s = lfsr_r >> 1;
    if (lfsr_r[0]) begin
      lfsr_next_s = (lfsr_r >> 1) ^ LFSR_TAPS;
    end else begin
      lfsr_next_s = lfsr_r >> 1;
    end
    arm_mask_s = ALL_ONES;
    if (RANDOM_EN != 0) begin
      if ({1'b0, popcount(lfsr_r[NUM_MODULES-1:0])} < MIN_ACT) begin
        arm_mask_s = ALL_ONES;
      end else begin
        arm_mask_s = lfsr_r[NUM_MODULES-1:0];
      end
    end else begin
      arm_mask_s = ALL_ONES;
    end
  end

  // ARMED-cycle next values: timer tick, defuse latch, strike count, outcome
  always_comb begin
    tick_s         = (presc_r == PRESC_LAST);
    timeout_s      = tick_s && (seconds_r == 16'd1);
    latch_next_s   = latch_r | (bus.module_defused & enable_r);
    // A module already defused can no longer hand out strikes
    valid_strike_s = bus.module_strike & enable_r & ~latch_r;
    strike_sum_s   = 6'(strikes_r) + 6'(popcount(valid_strike_s));
    strikes_next_s = strikes_r;
    if (strike_sum_s >= STRIKE_LIM) begin
      strikes_next_s = STRIKE_MAX;
    end else begin
      strikes_next_s = strike_sum_s[SW-1:0];
    end
    lose_s = (strike_sum_s >= STRIKE_LIM) || timeout_s;
    win_s  = ((latch_next_s & enable_r) == enable_r);
  end

  // Round state machine and all output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= S_IDLE;
      lfsr_r    <= LFSR_SEED;
      enable_r  <= {NUM_MODULES{1'b0}};
      latch_r   <= {NUM_MODULES{1'b0}};
      strikes_r <= {SW{1'b0}};
      seconds_r <= 16'd0;
      presc_r   <= {PW{1'b0}};
      accum_r   <= 1'b0;
      won_r     <= 1'b0;
      lost_r    <= 1'b0;
      one_hz_r  <= 1'b0;
    end else begin
      lfsr_r <= lfsr_next_s;
      case (state_r)
        S_IDLE: begin
          one_hz_r <= 1'b0;
          accum_r  <= 1'b0;
          if (bus.begin_setup) begin
            state_r <= S_SETUP;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_SETUP: begin
          enable_r  <= arm_mask_s;
          seconds_r <= TIME_INIT;
          strikes_r <= {SW{1'b0}};
          latch_r   <= {NUM_MODULES{1'b0}};
          presc_r   <= {PW{1'b0}};
          won_r     <= 1'b0;
          lost_r    <= 1'b0;
          one_hz_r  <= 1'b0;
          accum_r   <= 1'b1;
          state_r   <= S_ARMED;
        end
        S_ARMED: begin
          latch_r   <= latch_next_s;
          strikes_r <= strikes_next_s;
          if (tick_s) begin
            presc_r <= {PW{1'b0}};
          end else begin
            presc_r <= presc_r + PW'(1);
          end
          // The expiring second is not counted down: the display freezes at 1
          if (tick_s && !timeout_s && (seconds_r != 16'd0)) begin
            seconds_r <= seconds_r - 16'd1;
          end else begin
            seconds_r <= seconds_r;
          end
          if (lose_s) begin
            state_r  <= S_LOST;
            lost_r   <= 1'b1;
            accum_r  <= 1'b0;
            one_hz_r <= 1'b0;
          end else if (win_s) begin
            state_r  <= S_WON;
            won_r    <= 1'b1;
            accum_r  <= 1'b0;
            one_hz_r <= 1'b0;
          end else begin
            state_r  <= S_ARMED;
            accum_r  <= 1'b1;
            one_hz_r <= tick_s;
          end
        end
        S_WON, S_LOST: begin
          accum_r  <= 1'b0;
          one_hz_r <= 1'b0;
          if (bus.begin_setup) begin
            won_r   <= 1'b0;
            lost_r  <= 1'b0;
            state_r <= S_SETUP;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r  <= S_IDLE;
          accum_r  <= 1'b0;
          one_hz_r <= 1'b0;
          won_r    <= 1'b0;
          lost_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.enable       = enable_r;
  assign bus.accum_enable = accum_r;
  assign bus.game_won     = won_r;
  assign bus.game_lost    = lost_r;
  assign bus.strikes      = strikes_r;
  assign bus.seconds_left = seconds_r;
  assign bus.one_hz       = one_hz_r;
  assign bus.state        = state_r;

endmodule

// File: tb/tb_bomb_game_ctrl.sv
// Directed bench for bomb_game_ctrl: three instances cover fixed arming,
// a fast timer, and LFSR-based arming.
module tb_bomb_game_ctrl;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  bomb_game_ctrl_if #(.NUM_MODULES(4), .SW(2)) ifa ();
  bomb_game_ctrl_if #(.NUM_MODULES(4), .SW(2)) ifb ();
  bomb_game_ctrl_if #(.NUM_MODULES(8), .SW(2)) ifc ();

  bomb_game_ctrl #(.NUM_MODULES(4), .MAX_STRIKES(3), .TIME_SECONDS(300),
                   .CLK_HZ(27000000), .RANDOM_EN(0))
    dut_a (.clock(clock), .reset(reset), .bus(ifa.slave));

  bomb_game_ctrl #(.NUM_MODULES(4), .MAX_STRIKES(3), .TIME_SECONDS(3),
                   .CLK_HZ(10), .RANDOM_EN(0))
    dut_b (.clock(clock), .reset(reset), .bus(ifb.slave));

  bomb_game_ctrl #(.NUM_MODULES(8), .MAX_STRIKES(3), .TIME_SECONDS(300),
                   .CLK_HZ(27000000), .LFSR_SEED(16'hACE1), .RANDOM_EN(1),
                   .MIN_ACTIVE(1))
    dut_c (.clock(clock), .reset(reset), .bus(ifc.slave));

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clock    = 1'b0;
    reset    = 1'b1;
    ifa.begin_setup = 1'b0; ifa.module_defused = 4'd0; ifa.module_strike = 4'd0;
    ifb.begin_setup = 1'b0; ifb.module_defused = 4'd0; ifb.module_strike = 4'd0;
    ifc.begin_setup = 1'b0; ifc.module_defused = 8'd0; ifc.module_strike = 8'd0;

    // Reset state
    tick(); tick();
    check("rst_state",   32'(ifa.state), 32'd0);
    check("rst_enable",  32'(ifa.enable), 32'd0);
    check("rst_accum",   32'(ifa.accum_enable), 32'd0);
    check("rst_won",     32'(ifa.game_won), 32'd0);
    check("rst_lost",    32'(ifa.game_lost), 32'd0);
    check("rst_strikes", 32'(ifa.strikes), 32'd0);
    check("rst_seconds", 32'(ifa.seconds_left), 32'd0);
    check("rst_one_hz",  32'(ifa.one_hz), 32'd0);

    // Start a round: SETUP then ARMED
    reset = 1'b0;
    ifa.begin_setup = 1'b1;
    ifc.begin_setup = 1'b1;
    tick();
    check("setup_state", 32'(ifa.state), 32'd1);
    ifa.begin_setup = 1'b0;
    ifc.begin_setup = 1'b0;
    tick();
    check("armed_state",   32'(ifa.state), 32'd2);
    check("armed_enable",  32'(ifa.enable), 32'hF);
    check("armed_accum",   32'(ifa.accum_enable), 32'd1);
    check("armed_seconds", 32'(ifa.seconds_left), 32'd300);
    // LFSR one step after seed 0xACE1 is 0xE270 -> low byte 0x70
    check("lfsr_enable",   32'(ifc.enable), 32'h70);
    check("lfsr_state",    32'(ifc.state), 32'd2);

    // begin_setup while ARMED is ignored
    ifa.begin_setup = 1'b1;
    tick();
    ifa.begin_setup = 1'b0;
    check("armed_ignore_setup", 32'(ifa.state), 32'd2);

    // Defuse sequence 0,1,1,3,2 -> win after bit 2
    ifa.module_defused = 4'b0001; tick();
    ifa.module_defused = 4'b0010; tick();
    ifa.module_defused = 4'b0010; tick();
    ifa.module_defused = 4'b1000; tick();
    check("win_not_yet", 32'(ifa.state), 32'd2);
    check("win_not_yet_flag", 32'(ifa.game_won), 32'd0);
    ifa.module_defused = 4'b0100; tick();
    ifa.module_defused = 4'b0000;
    check("win_state", 32'(ifa.state), 32'd3);
    check("win_flag",  32'(ifa.game_won), 32'd1);
    check("win_accum", 32'(ifa.accum_enable), 32'd0);
    check("win_lost",  32'(ifa.game_lost), 32'd0);

    // WON is terminal: strikes ignored, flags held
    ifa.module_strike = 4'b0001; tick();
    ifa.module_strike = 4'b0000; tick();
    check("won_strikes_frozen", 32'(ifa.strikes), 32'd0);
    check("won_hold",           32'(ifa.game_won), 32'd1);
    check("won_enable_frozen",  32'(ifa.enable), 32'hF);

    // New round from WON
    ifa.begin_setup = 1'b1; tick();
    ifa.begin_setup = 1'b0;
    check("won_restart_state", 32'(ifa.state), 32'd1);
    check("won_restart_flag",  32'(ifa.game_won), 32'd0);
    tick();
    check("round2_state", 32'(ifa.state), 32'd2);

    // Strikes: 0101 counts 2, strike on defused bit 3 ignored, 0010 loses
    ifa.module_defused = 4'b1000; tick();
    ifa.module_defused = 4'b0000;
    ifa.module_strike = 4'b0101; tick();
    check("strike_two", 32'(ifa.strikes), 32'd2);
    check("strike_two_state", 32'(ifa.state), 32'd2);
    ifa.module_strike = 4'b1000; tick();
    check("strike_defused_ignored", 32'(ifa.strikes), 32'd2);
    ifa.module_strike = 4'b0010; tick();
    ifa.module_strike = 4'b0000;
    check("strike_three", 32'(ifa.strikes), 32'd3);
    check("lost_flag",    32'(ifa.game_lost), 32'd1);
    check("lost_state",   32'(ifa.state), 32'd4);
    check("lost_accum",   32'(ifa.accum_enable), 32'd0);

    // New round from LOST clears strikes
    ifa.begin_setup = 1'b1; tick();
    ifa.begin_setup = 1'b0;
    check("lost_restart_flag", 32'(ifa.game_lost), 32'd0);
    tick();
    check("round3_state",   32'(ifa.state), 32'd2);
    check("round3_strikes", 32'(ifa.strikes), 32'd0);
    check("round3_seconds", 32'(ifa.seconds_left), 32'd300);

    // Final defuse and third strike together: lose wins priority
    ifa.module_strike = 4'b1000; tick(); tick();
    ifa.module_strike = 4'b0000;
    check("tie_two_strikes", 32'(ifa.strikes), 32'd2);
    ifa.module_defused = 4'b0111; tick();
    check("tie_still_armed", 32'(ifa.state), 32'd2);
    ifa.module_defused = 4'b1000;
    ifa.module_strike  = 4'b1000;
    tick();
    ifa.module_defused = 4'b0000;
    ifa.module_strike  = 4'b0000;
    check("tie_lost", 32'(ifa.game_lost), 32'd1);
    check("tie_won",  32'(ifa.game_won), 32'd0);
    check("tie_state", 32'(ifa.state), 32'd4);

    // Reset in the middle of ARMED
    ifa.begin_setup = 1'b1; tick();
    ifa.begin_setup = 1'b0; tick();
    ifa.module_defused = 4'b0001; tick();
    ifa.module_defused = 4'b0000;
    reset = 1'b1; tick();
    reset = 1'b0;
    check("midrst_state",   32'(ifa.state), 32'd0);
    check("midrst_enable",  32'(ifa.enable), 32'd0);
    check("midrst_accum",   32'(ifa.accum_enable), 32'd0);
    check("midrst_seconds", 32'(ifa.seconds_left), 32'd0);
    check("midrst_strikes", 32'(ifa.strikes), 32'd0);
    ifa.begin_setup = 1'b1; tick();
    ifa.begin_setup = 1'b0; tick();
    ifa.module_defused = 4'b1110; tick();
    ifa.module_defused = 4'b0000;
    check("midrst_latch_cleared", 32'(ifa.state), 32'd2);

    // Timer: CLK_HZ=10, TIME_SECONDS=3
    ifb.begin_setup = 1'b1; tick();
    ifb.begin_setup = 1'b0; tick();
    check("tmr_state",   32'(ifb.state), 32'd2);
    check("tmr_seconds", 32'(ifb.seconds_left), 32'd3);
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k < 30) begin
        check("tmr_run_state",   32'(ifb.state), 32'd2);
        check("tmr_run_seconds", 32'(ifb.seconds_left), 32'(3 - (k / 10)));
        check("tmr_run_one_hz",  32'(ifb.one_hz), ((k == 10) || (k == 20)) ? 32'd1 : 32'd0);
      end else begin
        check("tmr_end_state",   32'(ifb.state), 32'd4);
        check("tmr_end_lost",    32'(ifb.game_lost), 32'd1);
        check("tmr_end_seconds", 32'(ifb.seconds_left), 32'd1);
      end
    end
    tick(); tick(); tick();
    check("tmr_frozen_seconds", 32'(ifb.seconds_left), 32'd1);
    check("tmr_frozen_one_hz",  32'(ifb.one_hz), 32'd0);
    check("tmr_frozen_state",   32'(ifb.state), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
